// File: rtl/draw_cmd_dispatcher.sv
// Draw-command sequencer: pops one FIFO word at a time, starts the matching engine,
// waits for its completion and owns the single VGA RAM write port.
module draw_cmd_dispatcher #(
    parameter int unsigned FF_DATA_WIDTH  = 32,
    parameter int unsigned VGA_ADDR_WIDTH = 19,
    parameter int unsigned COLOR_ID_WIDTH = 8,
    parameter int unsigned TIMEOUT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enb,
    input  logic                        ff_empty,
    output logic                        ff_rden,
    input  logic [FF_DATA_WIDTH-1:0]    ff_rdat,
    input  logic                        ff_rvld,
    output logic [FF_DATA_WIDTH-1:0]    eng_cmd,
    output logic [3:0]                  eng_vld,
    input  logic [3:0]                  eng_done,
    input  logic [4*VGA_ADDR_WIDTH-1:0] eng_addr,
    input  logic [4*COLOR_ID_WIDTH-1:0] eng_data,
    input  logic [3:0]                  eng_wren,
    output logic [VGA_ADDR_WIDTH-1:0]   addr,
    output logic [COLOR_ID_WIDTH-1:0]   data,
    output logic                        wren,
    output logic                        busy,
    output logic                        err_opcode,
    output logic                        err_timeout,
    output logic                        err_conflict,
    output logic [15:0]                 cmd_count
);
    localparam int unsigned NUM_ENG = 4;
    localparam int unsigned ENG_W   = 2;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        ISSUE     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                     state;
    state_t                     next_state;
    logic                       fetch;
    logic [OP_W-1:0]            opcode;
    logic                       dec_ok;
    logic                       dec_full;
    logic [ENG_W-1:0]           dec_sel;
    logic [ENG_W-1:0]           sel;
    logic                       full;
    logic [ENG_W-1:0]           owner;
    logic [NUM_ENG-1:0]         owner_mask;
    logic [TIMEOUT_WIDTH-1:0]   wd;
    logic [TIMEOUT_WIDTH-1:0]   wd_next;
    logic                       wd_expire;
    logic                       done_hit;
    logic [VGA_ADDR_WIDTH-1:0]  addr_sl [NUM_ENG];
    logic [COLOR_ID_WIDTH-1:0]  data_sl [NUM_ENG];

    assign opcode     = ff_rdat[FF_DATA_WIDTH-1 -: OP_W];
    assign owner_mask = NUM_ENG'(1) << owner;
    assign done_hit   = eng_done[owner];
    assign wd_next    = wd + TIMEOUT_WIDTH'(1);
    assign wd_expire  = &wd_next;
    assign ff_rden    = fetch & rst;

    // Opcode map; for the rectangle/char engines bit 0 splits parameter loads from commands
    always_comb begin : decode
        dec_ok   = 1'b1;
        dec_full = 1'b1;
        dec_sel  = '0;
        case (opcode)
            4'h0: dec_sel = ENG_W'(0);
            4'h1: dec_sel = ENG_W'(1);
            4'h9: begin
                dec_sel  = ENG_W'(2);
                dec_full = ff_rdat[0];
            end
            4'hA: begin
                dec_sel  = ENG_W'(3);
                dec_full = ff_rdat[0];
            end
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin : unpack_slices
        for (int unsigned i = 0; i < NUM_ENG; i++) begin
            addr_sl[i] = eng_addr[i*VGA_ADDR_WIDTH +: VGA_ADDR_WIDTH];
            data_sl[i] = eng_data[i*COLOR_ID_WIDTH +: COLOR_ID_WIDTH];
        end
    end

    always_ff @(posedge clk) begin : fsm_state
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin : fsm_next
        next_state = state;
        fetch      = 1'b0;
        case (state)
            IDLE: begin
                fetch = enb & ~ff_empty;
                if (fetch) begin
                    next_state = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (ff_rvld) begin
                    next_state = dec_ok ? ISSUE : IDLE;
                end
            end
            ISSUE: begin
                next_state = full ? WAIT_DONE : IDLE;
            end
            WAIT_DONE: begin
                if (done_hit || wd_expire) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Command latch, start pulse, watchdog and status
    always_ff @(posedge clk) begin : ctrl_regs
        if (!rst) begin
            eng_cmd     <= '0;
            eng_vld     <= '0;
            sel         <= '0;
            full        <= 1'b0;
            owner       <= '0;
            wd          <= '0;
            busy        <= 1'b0;
            err_opcode  <= 1'b0;
            err_timeout <= 1'b0;
            cmd_count   <= '0;
        end else begin
            eng_vld <= '0;
            busy    <= (next_state != IDLE);
            if (state == WAIT_DATA && ff_rvld) begin
                eng_cmd <= ff_rdat;
                sel     <= dec_sel;
                full    <= dec_full;
                if (dec_ok) begin
                    eng_vld <= NUM_ENG'(1) << dec_sel;
                end else begin
                    err_opcode <= 1'b1;
                end
            end
            if (state == ISSUE) begin
                owner <= sel;
                wd    <= '0;
            end
            if (state == WAIT_DONE) begin
                wd <= wd_next;
                if (done_hit) begin
                    cmd_count <= cmd_count + CNT_W'(1);
                end else if (wd_expire) begin
                    err_timeout <= 1'b1;
                end
            end
        end
    end

    // RAM write port follows the owner in every state so trailing writes still land
    always_ff @(posedge clk) begin : wr_port
        if (!rst) begin
            wren         <= 1'b0;
            addr         <= '0;
            data         <= '0;
            err_conflict <= 1'b0;
        end else begin
            wren <= eng_wren[owner];
            if (eng_wren[owner]) begin
                addr <= addr_sl[owner];
                data <= data_sl[owner];
            end
            if ((eng_wren & ~owner_mask) != '0) begin
                err_conflict <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_draw_cmd_dispatcher.sv
// Randomized bench for draw_cmd_dispatcher against a transaction-level model of FIFO,
// engines and RAM port.
module tb_draw_cmd_dispatcher;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 19;
    localparam int unsigned CW  = 8;
    localparam int unsigned TW  = 4;
    localparam int unsigned EAW = 4 * AW;
    localparam int unsigned EDW = 4 * CW;
    localparam int TMAX  = (1 << TW) - 1;
    localparam int NEVER = 1000;
    localparam int BIG   = 32'h3fff_ffff;

    logic           clk = 1'b0;
    logic           rst, enb, ff_empty, ff_rden, ff_rvld;
    logic [DW-1:0]  ff_rdat, eng_cmd;
    logic [3:0]     eng_vld, eng_done, eng_wren;
    logic [EAW-1:0] eng_addr;
    logic [EDW-1:0] eng_data;
    logic [AW-1:0]  addr;
    logic [CW-1:0]  data;
    logic           wren, busy, err_opcode, err_timeout, err_conflict;
    logic [15:0]    cmd_count;

    draw_cmd_dispatcher #(
        .FF_DATA_WIDTH (DW),
        .VGA_ADDR_WIDTH(AW),
        .COLOR_ID_WIDTH(CW),
        .TIMEOUT_WIDTH (TW)
    ) dut (
        .clk(clk), .rst(rst), .enb(enb), .ff_empty(ff_empty), .ff_rden(ff_rden),
        .ff_rdat(ff_rdat), .ff_rvld(ff_rvld), .eng_cmd(eng_cmd), .eng_vld(eng_vld),
        .eng_done(eng_done), .eng_addr(eng_addr), .eng_data(eng_data), .eng_wren(eng_wren),
        .addr(addr), .data(data), .wren(wren), .busy(busy), .err_opcode(err_opcode),
        .err_timeout(err_timeout), .err_conflict(err_conflict), .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state
    logic [DW-1:0] fifo_q[$];
    int            delay_q[$];
    bit            rvld_next;
    logic [DW-1:0] rdat_next;
    int            exp_start, exp_eng;
    bit            exp_full;
    logic [3:0]    exp_onehot;
    logic [DW-1:0] exp_word;
    int            idle_from;
    int            done_at[4];
    int            owner;
    int            active, active_start, active_end;
    logic          exp_wren;
    logic [AW-1:0] exp_addr;
    logic [CW-1:0] exp_data;
    int            exp_count;
    bit            exp_eop, exp_eto, exp_ecf;
    // Stimulus knobs
    bit            rand_enb, enb_val, stray_on, force_conflict;
    int            push_pct, to_push;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void spec_decode(input logic [DW-1:0] w, output bit ok,
                                        output int eng, output bit full);
        logic [3:0] op;
        op   = w[DW-1 -: 4];
        ok   = 1'b1;
        full = 1'b1;
        eng  = 0;
        if (op == 4'h0) eng = 0;
        else if (op == 4'h1) eng = 1;
        else if (op == 4'h9) begin eng = 2; full = w[0]; end
        else if (op == 4'hA) begin eng = 3; full = w[0]; end
        else ok = 1'b0;
    endfunction

    function automatic logic [DW-1:0] rand_cmd();
        logic [DW-1:0] w;
        logic [3:0]    op;
        int            r;
        w = DW'($urandom());
        r = int'($urandom_range(0, 8));
        if (r < 2) op = 4'h0;
        else if (r < 4) op = 4'h1;
        else if (r < 6) op = 4'h9;
        else if (r < 8) op = 4'hA;
        else begin
            op = 4'($urandom_range(2, 15));
            if (op == 4'h9 || op == 4'hA) op = 4'h7;
        end
        w[DW-1 -: 4] = op;
        return w;
    endfunction

    task automatic model_clear();
        fifo_q.delete();
        delay_q.delete();
        rvld_next = 1'b0;
        rdat_next = '0;
        exp_start = -1;
        exp_eng   = 0;
        exp_full  = 1'b0;
        exp_onehot = '0;
        exp_word  = '0;
        idle_from = 0;
        for (int i = 0; i < 4; i++) done_at[i] = -1;
        owner = 0;
        active = -1;
        active_start = -1;
        active_end = -1;
        exp_wren = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_count = 0;
        exp_eop = 1'b0;
        exp_eto = 1'b0;
        exp_ecf = 1'b0;
    endtask

    // One clock: drive at the falling edge, sample 1 time unit later, advance the model
    task automatic tick();
        logic [3:0]    dn, wr, own_mask;
        logic [DW-1:0] w;
        bit            ok, full, exp_rden, exp_busy;
        int            eng, d, act, j;
        @(negedge clk);
        cyc++;
        if (to_push > 0 && int'($urandom_range(0, 99)) < push_pct) begin
            fifo_q.push_back(rand_cmd());
            to_push--;
        end
        ff_empty = (fifo_q.size() == 0);
        ff_rvld  = rvld_next;
        ff_rdat  = rvld_next ? rdat_next : DW'($urandom());
        rvld_next = 1'b0;
        enb = rand_enb ? ($urandom_range(0, 3) != 0) : enb_val;
        act = (active >= 0 && cyc > active_start && cyc <= active_end) ? active : -1;
        dn = '0;
        for (int i = 0; i < 4; i++) if (done_at[i] == cyc) dn[i] = 1'b1;
        if (stray_on && $urandom_range(0, 7) == 0) begin
            j = int'($urandom_range(0, 3));
            if (j != act) dn[j] = 1'b1;
        end
        own_mask = 4'(1 << owner);
        wr = ($urandom_range(0, 2) == 0) ? own_mask : 4'b0000;
        eng_addr = EAW'({$urandom(), $urandom(), $urandom()});
        eng_data = EDW'($urandom());
        if (force_conflict) begin
            wr = 4'b0011;
            eng_addr[AW +: AW] = 19'h12345;
            eng_data[CW +: CW] = 8'h7E;
        end
        eng_wren = wr;
        eng_done = dn;
        #1;
        exp_busy = (cyc < idle_from);
        exp_rden = enb && !ff_empty && !exp_busy;
        check_eq("ff_rden", 64'(ff_rden), 64'(exp_rden));
        check_eq("busy", 64'(busy), 64'(exp_busy));
        check_eq("wren", 64'(wren), 64'(exp_wren));
        check_eq("addr", 64'(addr), 64'(exp_addr));
        check_eq("data", 64'(data), 64'(exp_data));
        check_eq("eng_vld", 64'(eng_vld), 64'((cyc == exp_start) ? exp_onehot : 4'b0000));
        if (cyc == exp_start) check_eq("eng_cmd", 64'(eng_cmd), 64'(exp_word));
        // RAM port result for next cycle uses the owner in force this cycle
        exp_wren = wr[owner];
        if (wr[owner]) begin
            exp_addr = eng_addr[owner*AW +: AW];
            exp_data = eng_data[owner*CW +: CW];
        end
        if ((wr & ~own_mask) != 4'b0000) exp_ecf = 1'b1;
        if (cyc == exp_start) begin
            owner = exp_eng;
            if (!exp_full) begin
                idle_from = cyc + 1;
            end else begin
                d = (delay_q.size() > 0) ? delay_q.pop_front() : int'($urandom_range(1, TMAX + 3));
                active = exp_eng;
                active_start = cyc;
                if (d <= TMAX) begin
                    done_at[exp_eng] = cyc + d;
                    active_end = cyc + d;
                    idle_from = cyc + d + 1;
                    exp_count++;
                end else begin
                    active_end = cyc + TMAX;
                    idle_from = cyc + TMAX + 1;
                    exp_eto = 1'b1;
                end
            end
        end
        if (ff_rden === 1'b1 && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            rvld_next = 1'b1;
            rdat_next = w;
            spec_decode(w, ok, eng, full);
            if (ok) begin
                exp_start  = cyc + 2;
                exp_eng    = eng;
                exp_onehot = 4'(1 << eng);
                exp_full   = full;
                exp_word   = w;
                idle_from  = BIG;
            end else begin
                exp_eop   = 1'b1;
                idle_from = cyc + 2;
            end
        end
    endtask

    task automatic run_until_quiet(input string tag, input int budget);
        int n;
        n = 0;
        while ((to_push > 0 || fifo_q.size() > 0 || rvld_next || cyc < idle_from) && n < budget) begin
            tick();
            n++;
        end
        check_eq({"drain_", tag}, 64'(n < budget), 64'(1));
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, "_cmd_count"}, 64'(cmd_count), 64'(16'(exp_count)));
        check_eq({tag, "_err_opcode"}, 64'(err_opcode), 64'(exp_eop));
        check_eq({tag, "_err_timeout"}, 64'(err_timeout), 64'(exp_eto));
        check_eq({tag, "_err_conflict"}, 64'(err_conflict), 64'(exp_ecf));
        check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        enb = 1'b0;
        ff_empty = 1'b1;
        ff_rvld = 1'b0;
        eng_done = '0;
        eng_wren = '0;
        @(negedge clk);
        cyc++;
        rst = 1'b1;
        model_clear();
        #1;
        check_eq("rst_ff_rden", 64'(ff_rden), 64'(0));
        check_eq("rst_eng_vld", 64'(eng_vld), 64'(0));
        check_eq("rst_eng_cmd", 64'(eng_cmd), 64'(0));
        check_eq("rst_wren", 64'(wren), 64'(0));
        check_eq("rst_addr", 64'(addr), 64'(0));
        check_eq("rst_data", 64'(data), 64'(0));
        check_status("rst");
    endtask

    // Tick until the model places engine e at least k cycles into its done wait
    task automatic wait_in_done(input string tag, input int e, input int k);
        int n;
        n = 0;
        while (!(active == e && cyc >= active_start + k && cyc < active_end) && n < 40) begin
            tick();
            n++;
        end
        check_eq({"reach_", tag}, 64'(n < 40), 64'(1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; enb = 1'b0; ff_empty = 1'b1; ff_rvld = 1'b0; ff_rdat = '0;
        eng_done = '0; eng_wren = '0; eng_addr = '0; eng_data = '0;
        rand_enb = 1'b0; enb_val = 1'b1; stray_on = 1'b0; force_conflict = 1'b0;
        push_pct = 0; to_push = 0;
        model_clear();
        do_reset();

        // Single pixel with a second word queued behind it
        fifo_q.push_back(32'h0012_34CC);
        fifo_q.push_back(32'h0056_78AA);
        delay_q.push_back(10);
        delay_q.push_back(10);
        run_until_quiet("pixel", 200);
        check_status("pixel");

        // Rect_px parameter load then full command
        fifo_q.push_back(32'h9000_0010);
        fifo_q.push_back(32'h9000_0011);
        delay_q.push_back(12);
        run_until_quiet("rect_px", 200);
        check_status("rect_px");

        // Undefined opcode followed by a char command
        fifo_q.push_back(32'h5123_4567);
        fifo_q.push_back(32'hA000_0001);
        delay_q.push_back(5);
        run_until_quiet("bad_op", 200);
        check_status("bad_op");

        // Engine never completes, next command still fetched
        fifo_q.push_back(32'h1000_0000);
        fifo_q.push_back(32'h0000_0001);
        delay_q.push_back(NEVER);
        delay_q.push_back(3);
        run_until_quiet("timeout", 200);
        check_status("timeout");

        // Owner engine 1 and engine 0 write in the same cycle
        fifo_q.push_back(32'h1000_0002);
        delay_q.push_back(8);
        wait_in_done("mux", 1, 1);
        force_conflict = 1'b1;
        tick();
        force_conflict = 1'b0;
        tick();
        check_eq("mux_addr", 64'(addr), 64'(19'h12345));
        check_eq("mux_data", 64'(data), 64'(8'h7E));
        check_eq("mux_wren", 64'(wren), 64'(1));
        check_eq("mux_err_conflict", 64'(err_conflict), 64'(1));
        run_until_quiet("mux", 200);
        check_status("mux");

        // Fetch held off while enb is low
        fifo_q.push_back(32'h0000_0003);
        delay_q.push_back(4);
        enb_val = 1'b0;
        repeat (10) tick();
        check_eq("enb0_fifo_level", 64'(fifo_q.size()), 64'(1));
        enb_val = 1'b1;
        run_until_quiet("enb", 200);
        check_status("enb");

        // Reset in the middle of a done wait
        fifo_q.push_back(32'h0000_0004);
        delay_q.push_back(NEVER);
        wait_in_done("rst_mid", 0, 3);
        do_reset();
        repeat (5) tick();
        check_status("post_rst");

        // Randomized traffic
        rand_enb = 1'b1;
        stray_on = 1'b1;
        push_pct = 30;
        to_push  = 150;
        run_until_quiet("random", 20000);
        check_status("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
